// File: rtl/rggen_wishbone_pipelined_adapter.sv
// Wishbone B4 pipelined slave to rggen register-bus adapter with an in-order request FIFO.
// Optional bus timeout enabled by defining RGGEN_WISHBONE_ADAPTER_TIMEOUT_EN.
module rggen_wishbone_pipelined_adapter #(
  parameter int                    ADDRESS_WIDTH     = 8,
  parameter int                    BUS_WIDTH         = 32,
  parameter int                    REQUEST_DEPTH     = 2,
  parameter logic [BUS_WIDTH-1:0]  DEFAULT_READ_DATA = '0,
  parameter int                    TIMEOUT_CYCLES    = 256
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_wb_cyc,
  input  logic                      i_wb_stb,
  input  logic                      i_wb_we,
  input  logic [ADDRESS_WIDTH-1:0]  i_wb_adr,
  input  logic [BUS_WIDTH-1:0]      i_wb_dat_w,
  input  logic [BUS_WIDTH/8-1:0]    i_wb_sel,
  output logic                      o_wb_stall,
  output logic                      o_wb_ack,
  output logic                      o_wb_err,
  output logic                      o_wb_rty,
  output logic [BUS_WIDTH-1:0]      o_wb_dat_r,
  output logic                      o_bus_valid,
  output logic [1:0]                o_bus_access,
  output logic [ADDRESS_WIDTH-1:0]  o_bus_address,
  output logic [BUS_WIDTH-1:0]      o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]    o_bus_strobe,
  input  logic                      i_bus_ready,
  input  logic [1:0]                i_bus_status,
  input  logic [BUS_WIDTH-1:0]      i_bus_read_data
);

  localparam int STRB_WIDTH = BUS_WIDTH / 8;
  localparam int PTR_WIDTH  = (REQUEST_DEPTH > 1) ? $clog2(REQUEST_DEPTH) : 1;
  localparam int CNT_WIDTH  = $clog2(REQUEST_DEPTH + 1);

  localparam logic [1:0]           RGGEN_READ  = 2'b10;
  localparam logic [1:0]           RGGEN_WRITE = 2'b11;
  localparam logic [PTR_WIDTH-1:0] LAST_PTR    = PTR_WIDTH'(REQUEST_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_COUNT  = CNT_WIDTH'(REQUEST_DEPTH);

  typedef struct packed {
    logic                     we;
    logic [ADDRESS_WIDTH-1:0] adr;
    logic [BUS_WIDTH-1:0]     dat;
    logic [STRB_WIDTH-1:0]    sel;
  } req_t;

  function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
    return (ptr == LAST_PTR) ? {PTR_WIDTH{1'b0}} : ptr + PTR_WIDTH'(1);
  endfunction

  req_t                 fifo_r [REQUEST_DEPTH];
  logic [PTR_WIDTH-1:0] head_r;
  logic [PTR_WIDTH-1:0] tail_r;
  logic [CNT_WIDTH-1:0] count_r;
  logic                 drain_r;
  logic                 ack_r;
  logic                 err_r;
  logic [BUS_WIDTH-1:0] dat_r_r;

  req_t head_s;
  logic empty_s;
  logic bus_valid_s;
  logic handshake_s;
  logic timeout_s;
  logic pop_s;
  logic push_s;
  logic stall_s;
  logic abort_s;
  logic keep_s;
  logic suppress_s;
  logic unused_s;

`ifdef RGGEN_WISHBONE_ADAPTER_TIMEOUT_EN
  localparam int TO_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TO_WIDTH-1:0] timer_r;

  // Consecutive stalled-cycle counter for the current head request
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      timer_r <= '0;
    end else if (bus_valid_s && !i_bus_ready && !timeout_s) begin
      timer_r <= timer_r + TO_WIDTH'(1);
    end else begin
      timer_r <= '0;
    end
  end

  // Timeout fires on the last allowed stalled cycle
  always_comb begin
    timeout_s = bus_valid_s && !i_bus_ready && (timer_r == TO_LAST);
  end
`else
  // Without the timeout feature the adapter waits for ready indefinitely
  always_comb begin
    timeout_s = 1'b0;
  end
`endif

  // Request-queue control decode
  always_comb begin
    head_s      = fifo_r[head_r];
    empty_s     = (count_r == {CNT_WIDTH{1'b0}});
    bus_valid_s = !empty_s;
    handshake_s = bus_valid_s && i_bus_ready;
    pop_s       = handshake_s || timeout_s;
    stall_s     = (count_r == FULL_COUNT) || drain_r;
    push_s      = i_wb_cyc && i_wb_stb && !stall_s;
    abort_s     = !i_wb_cyc;
    // an in-flight head must keep valid asserted until the register bus answers
    keep_s      = abort_s && bus_valid_s && !pop_s;
    suppress_s  = drain_r || abort_s;
    unused_s    = i_bus_status[0];
  end

  // Request storage; contents are only observed through the non-empty head
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      fifo_r[tail_r] <= '{we: i_wb_we, adr: i_wb_adr, dat: i_wb_dat_w, sel: i_wb_sel};
    end
  end

  // FIFO pointers, occupancy and abort-drain tracking
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      drain_r <= 1'b0;
    end else if (abort_s) begin
      if (keep_s) begin
        tail_r  <= next_ptr(head_r);
        count_r <= CNT_WIDTH'(1);
        drain_r <= 1'b1;
      end else begin
        head_r  <= '0;
        tail_r  <= '0;
        count_r <= '0;
        drain_r <= 1'b0;
      end
    end else begin
      if (pop_s) begin
        head_r  <= next_ptr(head_r);
        drain_r <= 1'b0;
      end
      if (push_s) begin
        tail_r <= next_ptr(tail_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_WIDTH'(1);
        2'b01:   count_r <= count_r - CNT_WIDTH'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Wishbone response pulses and captured read data
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      dat_r_r <= '0;
    end else begin
      ack_r <= handshake_s && !i_bus_status[1] && !suppress_s;
      err_r <= ((handshake_s && i_bus_status[1]) || timeout_s) && !suppress_s;
      if (handshake_s) begin
        dat_r_r <= i_bus_read_data;
      end else if (timeout_s) begin
        dat_r_r <= DEFAULT_READ_DATA;
      end else begin
        dat_r_r <= dat_r_r;
      end
    end
  end

  assign o_wb_stall       = stall_s;
  assign o_wb_ack         = ack_r && i_wb_cyc;
  assign o_wb_err         = err_r && i_wb_cyc;
  assign o_wb_rty         = 1'b0;
  assign o_wb_dat_r       = dat_r_r;
  assign o_bus_valid      = bus_valid_s;
  assign o_bus_access     = empty_s ? 2'b00 : (head_s.we ? RGGEN_WRITE : RGGEN_READ);
  assign o_bus_address    = empty_s ? {ADDRESS_WIDTH{1'b0}} : head_s.adr;
  assign o_bus_write_data = empty_s ? {BUS_WIDTH{1'b0}} : head_s.dat;
  assign o_bus_strobe     = empty_s ? {STRB_WIDTH{1'b0}} : head_s.sel;

endmodule
